// File: rtl/sram_controller_pkg.sv
// Shared definitions for the memory-stage SRAM controller: state encoding, SRAM geometry,
// and the byte-offset to half-word address mapping.
package sram_controller_pkg;

    localparam int unsigned SRAM_BASE = 1024;
    localparam int unsigned SRAM_AW   = 18;
    localparam int unsigned SRAM_DW   = 16;

    typedef enum logic [2:0] {
        StIdle,
        StLo,
        StHi,
        StWait,
        StDone
    } state_t;

    // Word index comes from offset[18:2]; the LSB selects the low or high half-word.
    function automatic logic [SRAM_AW-1:0] half_addr(input logic [31:0] offset, input logic hi);
        return {offset[SRAM_AW:2], hi};
    endfunction

endpackage

// File: rtl/sram_controller.sv
// Splits one 32-bit load/store into two 16-bit accesses on an asynchronous SRAM and holds
// ready low until the access, including its recovery wait, has completed.
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int unsigned BASE_ADDR   = SRAM_BASE,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [31:0]        address,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               ready,
    inout  wire  [SRAM_DW-1:0] SRAM_DQ,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_WE_N,
    output logic               SRAM_UB_N,
    output logic               SRAM_LB_N,
    output logic               SRAM_CE_N,
    output logic               SRAM_OE_N
);

    localparam logic [2:0] LP_WAIT_LAST = 3'(WAIT_CYCLES - 1);

    state_t               r_state;
    logic [2:0]           r_wcnt;
    logic [31:0]          r_rdata;
    logic [SRAM_AW-1:0]   r_addr;
    logic                 r_we_n;
    logic                 r_dq_oe;
    logic [SRAM_DW-1:0]   r_dq_out;

    logic                 w_request;
    logic [31:0]          w_offset;
    logic [SRAM_AW-1:0]   w_addr_lo;
    logic [SRAM_AW-1:0]   w_addr_hi;

    assign w_request = wr_en | rd_en;
    assign w_offset  = address - BASE_ADDR;
    assign w_addr_lo = half_addr(w_offset, 1'b0);
    assign w_addr_hi = half_addr(w_offset, 1'b1);

    // Bus outputs are registered one state ahead so they are valid for the whole LO/HI cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= StIdle;
            r_wcnt   <= 3'd0;
            r_rdata  <= 32'd0;
            r_addr   <= '0;
            r_we_n   <= 1'b1;
            r_dq_oe  <= 1'b0;
            r_dq_out <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_request) begin
                        r_state  <= StLo;
                        r_addr   <= w_addr_lo;
                        r_we_n   <= ~wr_en;
                        r_dq_oe  <= wr_en;
                        r_dq_out <= wdata[15:0];
                    end
                end
                StLo: begin
                    if (!wr_en) begin
                        r_rdata[15:0] <= SRAM_DQ;
                    end
                    r_state  <= StHi;
                    r_addr   <= w_addr_hi;
                    r_dq_out <= wdata[31:16];
                end
                StHi: begin
                    if (!wr_en) begin
                        r_rdata[31:16] <= SRAM_DQ;
                    end
                    r_state <= StWait;
                    r_wcnt  <= 3'd0;
                    r_addr  <= '0;
                    r_we_n  <= 1'b1;
                    r_dq_oe <= 1'b0;
                end
                StWait: begin
                    r_wcnt <= r_wcnt + 3'd1;
                    if (r_wcnt == LP_WAIT_LAST) begin
                        r_state <= StDone;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign ready     = ((r_state == StIdle) && !w_request) || (r_state == StDone);
    assign rdata     = r_rdata;
    assign SRAM_ADDR = r_addr;
    assign SRAM_WE_N = r_we_n;
    assign SRAM_DQ   = r_dq_oe ? r_dq_out : {SRAM_DW{1'bz}};
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller: behavioural SRAM on the bus, word-level reference
// memory, directed plus randomized load/store sequence.
module tb_sram_controller;

    localparam int unsigned BASE   = 1024;
    localparam int unsigned WAITC  = 2;
    localparam int unsigned LAT    = 4 + WAITC;
    localparam logic [15:0] PROBE  = 16'hC33C;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, rd_en;
    logic [31:0] address, wdata;
    logic [31:0] rdata;
    logic        ready;
    wire  [15:0] SRAM_DQ;
    logic [17:0] SRAM_ADDR;
    logic        SRAM_WE_N, SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N;

    logic        wr2;
    logic [31:0] rdata2;
    logic        ready2;
    wire  [15:0] dq2;
    logic [17:0] addr2;
    logic        we2_n, ub2_n, lb2_n, ce2_n, oe2_n;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural 256K x 16 SRAM; the bench drives PROBE whenever the SRAM is not being
    // written and no load is in progress, so a stray controller drive shows up on the bus.
    bit   [15:0] mem [0:262143];
    logic        tb_reading = 1'b0;

    assign SRAM_DQ = !SRAM_WE_N ? 16'hzzzz : (tb_reading ? mem[SRAM_ADDR] : PROBE);

    always @(posedge clk) begin
        if (!SRAM_WE_N) mem[SRAM_ADDR] <= SRAM_DQ;
    end

    // Reference: whole 32-bit words keyed by word index, plus last loaded value.
    logic [31:0] ref_mem [logic [16:0]];
    logic [31:0] ref_rdata = 32'd0;

    sram_controller #(.BASE_ADDR(BASE), .WAIT_CYCLES(WAITC)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address), .wdata(wdata),
        .rdata(rdata), .ready(ready), .SRAM_DQ(SRAM_DQ), .SRAM_ADDR(SRAM_ADDR),
        .SRAM_WE_N(SRAM_WE_N), .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N),
        .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N)
    );

    sram_controller #(.BASE_ADDR(BASE), .WAIT_CYCLES(4)) dut_w4 (
        .clk(clk), .rst(rst), .wr_en(wr2), .rd_en(1'b0), .address(32'd1024),
        .wdata(32'h0000BEEF), .rdata(rdata2), .ready(ready2), .SRAM_DQ(dq2), .SRAM_ADDR(addr2),
        .SRAM_WE_N(we2_n), .SRAM_UB_N(ub2_n), .SRAM_LB_N(lb2_n), .SRAM_CE_N(ce2_n),
        .SRAM_OE_N(oe2_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] word_of(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
        return off[18:2];
    endfunction

    function automatic logic [31:0] ref_read(input logic [16:0] w);
        return ref_mem.exists(w) ? ref_mem[w] : 32'd0;
    endfunction

    // Request inputs must stay put while ready is low.
    logic        mon_rdy_q  = 1'b1;
    logic [1:0]  mon_req_q  = 2'b00;
    logic [31:0] mon_addr_q = 32'd0;
    logic [31:0] mon_wd_q   = 32'd0;
    always @(negedge clk) begin
        if (!mon_rdy_q) begin
            check("hold_req", 32'({wr_en, rd_en}), 32'(mon_req_q));
            check("hold_addr", address, mon_addr_q);
            check("hold_wdata", wdata, mon_wd_q);
        end
        mon_rdy_q  <= ready;
        mon_req_q  <= {wr_en, rd_en};
        mon_addr_q <= address;
        mon_wd_q   <= wdata;
    end

    // One access from cycle 0 to the edge that closes DONE; inputs are left held afterwards.
    task automatic do_access(input logic wr, input logic rd, input logic [31:0] addr,
                             input logic [31:0] data);
        logic [16:0] w;
        logic [31:0] exp_rd;
        logic [17:0] exp_a;
        w          = word_of(addr);
        exp_rd     = ref_read(w);
        wr_en      = wr;
        rd_en      = rd;
        address    = addr;
        wdata      = data;
        tb_reading = !wr;
        for (int n = 0; n < int'(LAT); n++) begin
            @(negedge clk);
            check($sformatf("ready_c%0d", n), 32'(ready), 32'(n == int'(LAT) - 1));
            exp_a = (n == 1) ? {w, 1'b0} : (n == 2) ? {w, 1'b1} : 18'd0;
            check($sformatf("addr_c%0d", n), 32'(SRAM_ADDR), 32'(exp_a));
            check($sformatf("we_n_c%0d", n), 32'(SRAM_WE_N), 32'(!(wr && (n == 1 || n == 2))));
            if (wr) begin
                check($sformatf("dq_c%0d", n), 32'(SRAM_DQ),
                      32'((n == 1) ? data[15:0] : (n == 2) ? data[31:16] : PROBE));
            end
            if (n == int'(LAT) - 1) begin
                check("rdata_done", rdata, wr ? ref_rdata : exp_rd);
            end
        end
        if (wr) ref_mem[w] = data;
        else    ref_rdata  = exp_rd;
        @(posedge clk);
        #1;
    endtask

    task automatic do_idle(input int cycles);
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        tb_reading = 1'b0;
        for (int n = 0; n < cycles; n++) begin
            @(negedge clk);
            check("idle_ready", 32'(ready), 32'd1);
            check("idle_we_n", 32'(SRAM_WE_N), 32'd1);
            check("idle_addr", 32'(SRAM_ADDR), 32'd0);
            check("idle_dq", 32'(SRAM_DQ), 32'(PROBE));
            check("idle_rdata", rdata, ref_rdata);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int first_rdy;
        rst     = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        address = 32'd0;
        wdata   = 32'd0;
        wr2     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_we_n", 32'(SRAM_WE_N), 32'd1);
        check("rst_addr", 32'(SRAM_ADDR), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_dq", 32'(SRAM_DQ), 32'(PROBE));
        check("rst_ties", 32'({SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N}), 32'd0);
        rst = 1'b0;

        do_idle(3);
        do_access(1'b1, 1'b0, 32'd1024, 32'h12345678);
        do_access(1'b0, 1'b1, 32'd1024, 32'd0);
        check("readback", rdata, 32'h12345678);
        do_access(1'b1, 1'b0, 32'd1024, 32'hFFFFFFFF);
        check("write_keeps_rdata", rdata, 32'h12345678);
        do_idle(1);

        do_access(1'b1, 1'b0, 32'd1036, 32'hCAFEBABE);
        check("hw6", 32'(mem[6]), 32'h0000BABE);
        check("hw7", 32'(mem[7]), 32'h0000CAFE);
        do_access(1'b0, 1'b1, 32'd1036, 32'd0);
        check("offset_read", rdata, 32'hCAFEBABE);

        // Both enables high is a store; rdata must not change.
        do_access(1'b1, 1'b1, 32'd1043, 32'h0BADF00D);
        check("both_is_write", rdata, 32'hCAFEBABE);
        do_access(1'b0, 1'b1, 32'd1040, 32'd0);
        check("both_readback", rdata, 32'h0BADF00D);

        // Back-to-back with held inputs: no idle gap between accesses.
        do_access(1'b0, 1'b1, 32'd1036, 32'd0);
        do_access(1'b1, 1'b0, 32'd1044, 32'h5EED1234);
        do_access(1'b1, 1'b0, 32'd1044, 32'h5EED1234);
        do_idle(2);

        // Reset during HI of a store, request held throughout.
        wr_en   = 1'b1;
        rd_en   = 1'b0;
        address = 32'd1024;
        wdata   = 32'hA5A51111;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        ref_rdata = 32'd0;
        check("mid_rst_ready", 32'(ready), 32'd0);
        check("mid_rst_we_n", 32'(SRAM_WE_N), 32'd1);
        check("mid_rst_addr", 32'(SRAM_ADDR), 32'd0);
        check("mid_rst_dq", 32'(SRAM_DQ), 32'(PROBE));
        check("mid_rst_rdata", rdata, 32'd0);
        check("mid_rst_hw0", 32'(mem[0]), 32'h00001111);
        do_access(1'b1, 1'b0, 32'd1024, 32'hA5A51111);
        do_access(1'b0, 1'b1, 32'd1024, 32'd0);
        check("restart_read", rdata, 32'hA5A51111);

        for (int i = 0; i < 24; i++) begin
            int unsigned op;
            logic [31:0] a;
            op = $urandom_range(0, 2);
            a  = 32'(BASE) + 32'($urandom_range(0, 31) * 4) + 32'($urandom_range(0, 3));
            do_access(op != 0, op != 1, a, $urandom);
        end
        do_idle(2);

        // Longer recovery: first ready at cycle 7, i.e. latency 8.
        wr2       = 1'b1;
        first_rdy = -1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (ready2 && first_rdy < 0) first_rdy = n;
        end
        check("w4_latency", 32'(first_rdy + 1), 32'd8);
        wr2 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
# sram_controller

Memory-stage controller for the pipelined core. It turns one 32-bit load/store per instruction into two 16-bit accesses on an external asynchronous SRAM. It holds `ready` low until the access completes, and the top level uses `~ready` as the pipeline freeze. It sits between the EX/MEM and MEM/WB registers, so its completion timing decides when `MEM_Dest`/`MEM_WB_EN` advance into the WB slot seen by the forwarding logic.

## Interface
Parameters:
- `BASE_ADDR`, 1024: byte address mapped to SRAM word 0.
- `WAIT_CYCLES`, 2: idle recovery cycles after the two half-word accesses (legal range 1..7).

Ports:
- `clk`, input, 1: single clock; all state on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `wr_en`, input, 1: store request (MEM_W_EN), held stable while `ready`=0.
- `rd_en`, input, 1: load request (MEM_R_EN), held stable while `ready`=0.
- `address`, input, 32: byte address (ALU result).
- `wdata`, input, 32: store data (Val_Rm).
- `rdata`, output, 32: registered load data.
- `ready`, output, 1: access complete / no access pending; freeze = `~ready`.
- `SRAM_DQ`, inout, 16: SRAM data bus.
- `SRAM_ADDR`, output, 18: SRAM half-word address.
- `SRAM_WE_N`, output, 1: write enable, active low.
- `SRAM_UB_N`, `SRAM_LB_N`, `SRAM_CE_N`, `SRAM_OE_N`, output, 1 each: tied to 0.

## Operation
- Address map: `offset = address - BASE_ADDR` (32-bit unsigned). `word = offset[18:2]`. Low half is at `{word,1'b0}` and high half at `{word,1'b1}`. `address[1:0]` is ignored. There is no range check.
- Request = `wr_en | rd_en`. If both are high, the access is a write and `rd_en` is ignored.
- FSM states are IDLE, LO, HI, WAIT, DONE. A counter `wcnt` (3 bits) is used in WAIT.
- IDLE: if a request is present, go to LO; otherwise stay in IDLE.
- LO: drive `SRAM_ADDR` with the low-half address.
  - Write: `SRAM_WE_N`=0 and `SRAM_DQ` driven with `wdata[15:0]`.
  - Read: `SRAM_DQ` is high-Z and `rdata[15:0]` is captured at the closing edge.
  - Next state: HI.
- HI: drive `SRAM_ADDR` with the high-half address.
  - Write: `SRAM_DQ` driven with `wdata[31:16]`.
  - Read: `rdata[31:16]` is captured.
  - Next state: WAIT with `wcnt`=0.
- WAIT: `SRAM_WE_N`=1 and `SRAM_DQ` high-Z. Increment `wcnt`; when `wcnt`==`WAIT_CYCLES-1`, go to DONE.
- DONE: `ready`=1. Go to IDLE unconditionally, even though the request inputs are still asserted.
- `ready` is combinational: `(state==IDLE & ~request) | state==DONE`.
- `SRAM_DQ` is driven only in LO/HI during a write. In every other state and cycle it is high-Z.
- `rdata` holds its value between accesses. A write access does not modify it.
- `SRAM_ADDR` is 0 in IDLE, WAIT and DONE.

## Timing
- Cycle 0 is the first IDLE cycle with a request present; `ready` drops in that same cycle.
- LO is cycle 1, HI is cycle 2, WAIT spans cycles 3..2+`WAIT_CYCLES`, and DONE is cycle 3+`WAIT_CYCLES`.
- Latency is 4+`WAIT_CYCLES` cycles, which is 6 by default. `ready`=1 only in the last cycle.
- The pipeline advances at the edge that closes DONE. The next instruction's request is first seen in IDLE the following cycle, so back-to-back accesses have no gap beyond IDLE→LO.
- Reset values: state=IDLE, `wcnt`=0, `rdata`=0, `SRAM_WE_N`=1, `SRAM_DQ` high-Z, `SRAM_ADDR`=0.
  - `ready` after reset equals `~request`.
- Reset in any state (including mid-write) reaches these values at the next edge. A partial write to SRAM is accepted.
- Request inputs changing while `ready`=0 is a protocol violation; behaviour is undefined and the bench asserts it.

## Structure
- Shared package: state encoding (IDLE..DONE), `SRAM_BASE`=1024, `SRAM_AW`=18, `SRAM_DW`=16.
- Implemented as a single module. Tristate is done with a continuous assign on `SRAM_DQ`.
- The bench uses a behavioural 256K×16 `sram_model`, which is not part of RTL.

## Test plan
- **Idle:** no request → `ready`=1, `SRAM_WE_N`=1, `SRAM_DQ`=Z, `SRAM_ADDR`=0 on every cycle.
- **Write:** write 0x12345678 to address 1024.
  - Cycle 1: `SRAM_ADDR`=0, DQ=0x5678, WE_N=0.
  - Cycle 2: `SRAM_ADDR`=1, DQ=0x1234, WE_N=0.
  - `ready`=0 for cycles 0–4 and 1 in cycle 5.
- **Readback:** read address 1024 → `rdata`=0x12345678 in cycle 5. A subsequent write of 0xFFFFFFFF leaves `rdata` unchanged.
- **Offset:** write 0xCAFEBABE to 1036 → SRAM half-words 6=0xBABE and 7=0xCAFE; read 1036 returns 0xCAFEBABE.
- **Reset mid-access:** `rst`=1 during cycle 2 of a write → next cycle IDLE, WE_N=1, DQ=Z, `rdata`=0.
  - Half-word 0 holds the new low half.
  - The request is still held, so the access restarts after `rst` drops.
- **Back-to-back:** read then write with held inputs → exactly two 6-cycle accesses with one DONE each.
  - `wr_en`=`rd_en`=1 performs a write.
  - `WAIT_CYCLES`=4 gives latency 8.
